// File: rtl/mem_if_pkg.sv
// Shared types and constants for the CPU data-memory responder.
package mem_if_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // Value driven on rsp_err for a misaligned or out-of-range access
  localparam logic ERR_BAD_ADDR = 1'b1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic              write;
    logic [31:0]       addr;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_req_t;
endpackage

// File: rtl/mem_word_array.sv
// Word-wide storage with per-byte write enables and a registered read port.
module mem_word_array
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [BE_W-1:0]                be,
  input  logic [WORD_W-1:0]              wdata,
  output logic [WORD_W-1:0]              rdata
);
  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  // Contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one request, waits WAIT_STATES cycles, commits and responds.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);
  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  mem_req_t    req_q, req_d;
  logic        err_q, err_d;

  mem_req_t    req_in, cur;
  logic        commit, bad;
  logic [31:0] word_off;
  logic [WORD_W-1:0] arr_rdata;

  assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (WAIT_STATES == 0) state_d = RESP;
        else begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_STATES - 1);
        end
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so the
  // live request must be used instead of the capture registers.
  always_comb begin
    req_d    = (state_q == IDLE && req_valid) ? req_in : req_q;
    cur      = (state_q == IDLE) ? req_in : req_q;
    commit   = (state_d == RESP) && (state_q != RESP);
    word_off = (cur.addr - ADDR_BASE) >> 2;
    bad      = (cur.addr[1:0] != 2'b00) || (word_off >= DEPTH_L);
    err_d    = commit ? (bad ? ERR_BAD_ADDR : 1'b0) : err_q;
  end

  mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .en    (commit),
    .we    (cur.write && !bad),
    .idx   (word_off[IDX_W-1:0]),
    .be    (cur.be),
    .wdata (cur.wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !req_q.write && !err_q) ? arr_rdata : '0;
    stall     = (state_q == IDLE && req_valid) || (state_q == WAIT);
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench: two responders (2 wait states at base 0, and 0 wait states at base 0x100) vs. a word-array model.
module tb_data_mem_responder;
  localparam int          DA = 256, WSA = 2;
  localparam logic [31:0] BA = 32'h0;
  localparam int          DB = 16,  WSB = 0;
  localparam logic [31:0] BB = 32'h100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        v, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  bit          sel;
  logic        vld_a, vld_b;
  logic        rdy_a, rv_a, er_a, st_a, rdy_b, rv_b, er_b, st_b;
  logic [31:0] rd_a, rd_b;

  assign vld_a = v & ~sel;
  assign vld_b = v & sel;

  data_mem_responder #(.DEPTH_WORDS(DA), .WAIT_STATES(WSA), .ADDR_BASE(BA)) dut_a (
    .clk(clk), .reset(reset), .req_valid(vld_a), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_ready(rdy_a), .rsp_valid(rv_a),
    .rsp_rdata(rd_a), .rsp_err(er_a), .stall(st_a));

  data_mem_responder #(.DEPTH_WORDS(DB), .WAIT_STATES(WSB), .ADDR_BASE(BB)) dut_b (
    .clk(clk), .reset(reset), .req_valid(vld_b), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_ready(rdy_b), .rsp_valid(rv_b),
    .rsp_rdata(rd_b), .rsp_err(er_b), .stall(st_b));

  wire        c_rdy = sel ? rdy_b : rdy_a;
  wire        c_rv  = sel ? rv_b  : rv_a;
  wire        c_er  = sel ? er_b  : er_a;
  wire        c_st  = sel ? st_b  : st_a;
  wire [31:0] c_rd  = sel ? rd_b  : rd_a;

  int vecs = 0, miscompares = 0;

  logic [31:0] mA [DA];
  logic [31:0] mB [DB];

  // Reference: decide error, apply store with byte merge, return expected load data
  task automatic model(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] erd, output bit eer);
    logic [31:0] off, old;
    int depth;
    off   = (a - (s ? BB : BA)) / 4;
    depth = s ? DB : DA;
    eer   = (a % 4 != 0) || (off >= 32'(depth));
    erd   = 32'h0;
    if (!eer) begin
      old = s ? mB[off] : mA[off];
      if (w) begin
        for (int i = 0; i < 4; i++) if (be[i]) old[8*i +: 8] = d[8*i +: 8];
        if (s) mB[off] = old; else mA[off] = old;
      end else erd = old;
    end
  endtask

  // Runs one request on the selected DUT; leaves garbage on the request lines while busy
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     output logic [31:0] rd, output bit er, output int lat, output int stc,
                     output bit rsp_clean);
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d; req_be = be; v = 1'b1;
    #1;
    stc = c_st ? 1 : 0;
    lat = -1; rd = 'x; er = 1'b0; rsp_clean = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c_rv) begin
        lat = c; rd = c_rd; er = c_er; rsp_clean = !c_rdy && !c_st;
        break;
      end
      if (c_st) stc++;
      req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    end
    v = 1'b0;
  endtask

  task automatic run_check(input string nm, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
    logic [31:0] rd, erd; bit er, eer, cl; int lat, stc, ws;
    ws = sel ? WSB : WSA;
    txn(w, a, d, be, rd, er, lat, stc, cl);
    model(sel, w, a, d, be, erd, eer);
    vecs++;
    if (lat !== ws + 1 || stc !== ws + 1 || !cl) begin
      miscompares++;
      $display("FAIL %s timing addr=%h: lat=%0d stall_cycles=%0d clean=%0d, need lat=%0d stall=%0d clean=1",
               nm, a, lat, stc, cl, ws + 1, ws + 1);
    end
    vecs++;
    if (rd !== erd || er !== eer) begin
      miscompares++;
      $display("FAIL %s data addr=%h: rdata=%h err=%0d, need rdata=%h err=%0d", nm, a, rd, er, erd, eer);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; v = 1'b0; sel = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (2) @(negedge clk);
    vecs++;
    if ({rdy_a, rv_a, rd_a, er_a, st_a} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_a: ready=%b valid=%b rdata=%h err=%b stall=%b, need 1 0 0 0 0",
               rdy_a, rv_a, rd_a, er_a, st_a);
    end
    vecs++;
    if ({rdy_b, rv_b, rd_b, er_b, st_b} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_b: ready=%b valid=%b rdata=%h err=%b stall=%b, need 1 0 0 0 0",
               rdy_b, rv_b, rd_b, er_b, st_b);
    end
    reset = 1'b0;
  endtask

  task automatic test_latency();
    logic [31:0] rd; bit er, cl; int lat, stc;
    sel = 1'b0;
    txn(1'b0, 32'h40, 32'h0, 4'hF, rd, er, lat, stc, cl);
    vecs++;
    if (lat !== 3 || stc !== 3 || !cl || er !== 1'b0) begin
      miscompares++;
      $display("FAIL first_load: lat=%0d stall=%0d clean=%0d err=%0d, need 3 3 1 0", lat, stc, cl, er);
    end
  endtask

  task automatic test_fill();
    sel = 1'b0;
    for (int i = 0; i < 16; i++) run_check("fill_a", 1'b1, BA + 32'(4 * i), $urandom, 4'hF);
    sel = 1'b1;
    for (int i = 0; i < DB; i++) run_check("fill_b", 1'b1, BB + 32'(4 * i), $urandom, 4'hF);
  endtask

  task automatic test_store_load();
    sel = 1'b0;
    run_check("store_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    run_check("load_full",  1'b0, 32'h10, 32'h0, 4'h0);
    run_check("store_byte", 1'b1, 32'h10, 32'h000000AA, 4'b0001);
    run_check("load_byte",  1'b0, 32'h10, 32'h0, 4'hF);
    run_check("store_be0",  1'b1, 32'h10, 32'h12345678, 4'h0);
    run_check("load_be0",   1'b0, 32'h10, 32'h0, 4'h5);
  endtask

  task automatic test_errors();
    sel = 1'b0;
    run_check("misalign_ld", 1'b0, 32'h13, 32'h0, 4'hF);
    run_check("oor_store",   1'b1, 32'h400, 32'hFFFFFFFF, 4'hF);
    run_check("word0_keep",  1'b0, 32'h0, 32'h0, 4'hF);
    run_check("last_word_a", 1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF);
    run_check("last_word_a", 1'b0, 32'h3FC, 32'h0, 4'hF);
    sel = 1'b1;
    run_check("below_base",  1'b1, 32'hFC, 32'h55555555, 4'hF);
    run_check("past_end_b",  1'b0, BB + 32'(4 * DB), 32'h0, 4'hF);
    run_check("last_word_b", 1'b0, BB + 32'(4 * (DB - 1)), 32'h0, 4'hF);
  endtask

  task automatic test_reset_mid();
    int seen;
    sel = 1'b0;
    run_check("pre_store", 1'b1, 32'h20, 32'h11111111, 4'hF);
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF; v = 1'b1;
    @(negedge clk);
    v = 1'b0; reset = 1'b1;
    #1;
    vecs++;
    if (rdy_a !== 1'b1 || rv_a !== 1'b0 || st_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: ready=%b valid=%b stall=%b, need 1 0 0", rdy_a, rv_a, st_a);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rv_a) seen++;
    end
    vecs++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_rsp: responses=%0d, need 0", seen);
    end
    run_check("reset_mid_load", 1'b0, 32'h20, 32'h0, 4'hF);
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2; bit x1, x2;
    sel = 1'b1;
    model(1'b1, 1'b0, BB + 32'h8, 32'h0, 4'hF, e1, x1);
    model(1'b1, 1'b0, BB + 32'h2C, 32'h0, 4'hF, e2, x2);
    @(negedge clk);
    req_write = 1'b0; req_addr = BB + 32'h8; req_be = 4'hF; v = 1'b1;
    @(negedge clk);
    vecs++;
    if (rv_b !== 1'b1 || rdy_b !== 1'b0 || st_b !== 1'b0 || rd_b !== e1 || er_b !== x1) begin
      miscompares++;
      $display("FAIL b2b_resp1: valid=%b ready=%b stall=%b rdata=%h err=%b, need 1 0 0 %h %b",
               rv_b, rdy_b, st_b, rd_b, er_b, e1, x1);
    end
    req_addr = BB + 32'h2C;
    @(negedge clk);
    vecs++;
    if (rv_b !== 1'b0 || rdy_b !== 1'b1 || st_b !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept2: valid=%b ready=%b stall=%b, need 0 1 1", rv_b, rdy_b, st_b);
    end
    @(negedge clk);
    v = 1'b0;
    vecs++;
    if (rv_b !== 1'b1 || rd_b !== e2 || er_b !== x2) begin
      miscompares++;
      $display("FAIL b2b_resp2: valid=%b rdata=%h err=%b, need 1 %h %b", rv_b, rd_b, er_b, e2, x2);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, base; int k;
    for (int n = 0; n < 150; n++) begin
      sel  = 1'($urandom);
      base = sel ? BB : BA;
      k    = $urandom_range(0, 19);
      if (k < 14)      a = base + 32'(4 * $urandom_range(0, 15));
      else if (k < 17) a = base + 32'($urandom_range(0, 63)) | 32'($urandom_range(1, 3));
      else             a = sel ? (k == 17 ? base - 32'(4 * $urandom_range(1, 8)) : base + 32'(4 * DB))
                               : 32'(4 * DA) + 32'(4 * $urandom_range(0, 100));
      run_check("random", 1'($urandom), a, $urandom, 4'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_store_load();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
